// File: rtl/data_sram_resp_pkg.sv
// Shared types and helpers for the data-SRAM responder.
// Defining DATA_SRAM_BYTE_STROBE_EN enables per-byte write strobes.
package data_sram_resp_pkg;

  localparam int DATA_SRAM_WEN_WD = 8;
  localparam int RESP_BUS_WD      = 66;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } sram_state_e;

  typedef struct packed {
    logic        err;
    logic        valid;
    logic [63:0] rdata;
  } resp_t;

  function automatic logic [63:0] merge_bytes(
    input logic [63:0]                 old_w,
    input logic [63:0]                 new_w,
    input logic [DATA_SRAM_WEN_WD-1:0] wen
  );
    logic [63:0] res;
    for (int i = 0; i < DATA_SRAM_WEN_WD; i++) begin
      res[8*i +: 8] = wen[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_resp_pipe.sv
// LATENCY-deep {err, valid, rdata} response pipeline with synchronous flush.
// rdata only advances with a valid response, so the output holds the last read.
module data_sram_resp_pipe
  import data_sram_resp_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RESP_BUS_WD-1:0] resp_i,
  output logic [RESP_BUS_WD-1:0] resp_o
);

  resp_t in_s;
  resp_t stage_q [LATENCY];

  assign in_s   = resp_t'(resp_i);
  assign resp_o = stage_q[LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0].valid <= in_s.valid;
      stage_q[0].err   <= in_s.err;
      if (in_s.valid) begin
        stage_q[0].rdata <= in_s.rdata;
      end
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i].valid <= stage_q[i-1].valid;
        stage_q[i].err   <= stage_q[i-1].err;
        if (stage_q[i-1].valid) begin
          stage_q[i].rdata <= stage_q[i-1].rdata;
        end
      end
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: clears DEPTH x 64-bit memory after reset, then serves
// one request per cycle with reads returned LATENCY cycles later.
// Optional macro DATA_SRAM_BYTE_STROBE_EN: honour individual wen bits on writes.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        data_sram_en,
  input  logic [DATA_SRAM_WEN_WD-1:0] data_sram_wen,
  input  logic [63:0]                 data_sram_addr,
  input  logic [63:0]                 data_sram_wdata,
  output logic                        req_ready,
  output logic [63:0]                 data_sram_rdata,
  output logic                        rdata_valid,
  output logic                        err
);

  localparam int IW = $clog2(DEPTH);

  sram_state_e   state_q;
  logic [IW-1:0] clr_idx_q;
  logic          req_ready_q;
  logic [63:0]   mem_q [DEPTH];

  logic          accept_s;
  logic          is_wr_s;
  logic          oor_s;
  logic          addr_unused_s;
  logic [IW-1:0] idx_s;
  logic [63:0]   rd_word_s;
  logic [63:0]   wr_word_d;
  resp_t         resp_d;
  resp_t         resp_q;

  assign idx_s         = data_sram_addr[3 +: IW];
  assign oor_s         = |data_sram_addr[63:3+IW];
  assign addr_unused_s = ^data_sram_addr[2:0];
  assign accept_s      = data_sram_en && req_ready_q;
  assign is_wr_s       = |data_sram_wen;
  assign rd_word_s     = mem_q[idx_s];

  always_comb begin
    resp_d       = '0;
    resp_d.valid = accept_s && !is_wr_s;
    resp_d.err   = accept_s && oor_s;
    resp_d.rdata = oor_s ? 64'd0 : rd_word_s;
`ifdef DATA_SRAM_BYTE_STROBE_EN
    wr_word_d    = merge_bytes(rd_word_s, data_sram_wdata, data_sram_wen);
`else
    wr_word_d    = data_sram_wdata;
`endif
  end

  // Clear sequencer: one word per cycle, then hold READY until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      clr_idx_q   <= '0;
      req_ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (clr_idx_q == IW'(DEPTH - 1)) begin
            state_q     <= S_READY;
            req_ready_q <= 1'b1;
          end else begin
            clr_idx_q   <= clr_idx_q + IW'(1);
            req_ready_q <= 1'b0;
          end
        end
        S_READY: begin
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_CLEAR;
          clr_idx_q   <= '0;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == S_CLEAR) begin
      mem_q[clr_idx_q] <= 64'd0;
    end else if (!reset && accept_s && is_wr_s && !oor_s) begin
      mem_q[idx_s] <= wr_word_d;
    end
  end

  data_sram_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk    (clk),
    .reset  (reset),
    .resp_i (resp_d),
    .resp_o (resp_q)
  );

  assign req_ready       = req_ready_q;
  assign data_sram_rdata = resp_q.rdata;
  assign rdata_valid     = resp_q.valid;
  assign err             = resp_q.err;

endmodule
